v_pipe_update_ctrl: RTL and testbench
=====================================

V_PIPE_UPDATE_CTRL -- requirements
Module: v_pipe_update_ctrl

Interface
REQ-001 SHALL have parameter CLR_IDX_W, default $clog2(cfg_pkg::ENTRIES_N), width of the clear-sweep index.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have the command ingress ports below.
- i_cmd_vld  in  1  command valid.
- i_cmd_op  in  2  opcode: 0 NOP, 1 INSERT, 2 DELETE, 3 CLEAR.
- i_cmd_key  in  v_pkg::key_t  command key.
- o_cmd_rdy  out  1  command accept.
REQ-004 SHALL have the compare-datapath ports below.
- o_pipe_key_r  out  v_pkg::key_t  registered key driven to the compare block.
- i_match_hit  in  1  compare hit.
- i_match_full  in  1  all entries valid.
- i_match_sel  in  ENTRIES_N  one-hot hit position.
- i_mask_cmp  in  ENTRIES_N  ordering mask.
REQ-005 SHALL have the state-update ports below.
- o_upd_vld  out  1  update strobe.
- o_upd_op  out  2  1 INSERT-new, 2 DELETE, 3 MODIFY-existing.
- o_upd_sel  out  ENTRIES_N  target entry one-hot (DELETE/MODIFY).
- o_upd_mask  out  ENTRIES_N  shift mask (INSERT-new/DELETE).
- o_clr_vld  out  1  clear strobe.
- o_clr_idx  out  CLR_IDX_W  entry being cleared.
REQ-006 SHALL have the response ports below.
- o_rsp_vld  out  1  response valid.
- o_rsp_status  out  2  0 OK, 1 FULL, 2 NOTFOUND.
- i_rsp_rdy  in  1  response accept.

Function
REQ-007 SHALL implement FSM states IDLE, CMP, UPD, CLR, RSP.
REQ-008 SHALL assert o_cmd_rdy only in IDLE; a transfer is i_cmd_vld & o_cmd_rdy.
REQ-009 On transfer of INSERT or DELETE: register i_cmd_key into o_pipe_key_r, register op, go to CMP.
REQ-010 On transfer of NOP: go directly to RSP with status OK; o_pipe_key_r unchanged.
REQ-011 On transfer of CLEAR: clear o_clr_idx to 0, go to CLR.
REQ-012 In CMP (exactly one cycle): sample i_match_hit, i_match_full, i_match_sel, i_mask_cmp into internal registers; go to UPD.
REQ-013 In UPD (exactly one cycle), the decision SHALL follow the sampled op and flags:
- INSERT & hit: o_upd_vld=1, o_upd_op=MODIFY, o_upd_sel=sampled sel, status OK.
- INSERT & !hit & !full: o_upd_vld=1, op INSERT-new, o_upd_mask=sampled mask, status OK.
- INSERT & !hit & full: o_upd_vld=0, status FULL.
- DELETE & hit: o_upd_vld=1, op DELETE, sel and mask driven, status OK.
- DELETE & !hit: o_upd_vld=0, status NOTFOUND.
- In every case, next state SHALL be RSP.
REQ-014 o_upd_vld SHALL be a single-cycle pulse, asserted only in UPD; o_upd_op/sel/mask SHALL be 0 whenever o_upd_vld=0.
REQ-015 In CLR: o_clr_vld=1 every cycle; o_clr_idx increments by 1 per cycle from 0 to ENTRIES_N-1; after idx ENTRIES_N-1, go to RSP with status OK (exactly ENTRIES_N strobes, no wrap).
REQ-016 In RSP: o_rsp_vld=1 and o_rsp_status stable until i_rsp_rdy=1; on acceptance go to IDLE.
REQ-017 Latency for INSERT/DELETE SHALL be: accept at cycle T, CMP at T+1, UPD at T+2, o_rsp_vld first at T+3; minimum command interval 4 cycles with i_rsp_rdy held 1.
REQ-018 Only one command SHALL be in flight; i_cmd_vld while not IDLE is ignored (o_cmd_rdy=0).
REQ-019 Compare inputs outside CMP SHALL have no effect on state or outputs.

Reset
REQ-020 Asserting arst_n low SHALL asynchronously force IDLE, and SHALL force o_cmd_rdy=1 after release; every other output SHALL be 0, including o_pipe_key_r, o_clr_idx, and o_rsp_status.
REQ-021 Reset mid-operation (CMP/UPD/CLR/RSP) SHALL abandon the command with no further update, clear, or response strobes.

Verification
REQ-022 INSERT key 0x10 with hit=0, full=0, mask=0x03: o_upd_vld pulses at T+2 with op 1 and mask 0x03, then rsp OK at T+3.
REQ-023 INSERT with hit=0, full=1: no o_upd_vld; rsp FULL at T+3.
REQ-024 DELETE with hit=1, sel=0x04: o_upd_vld with op 2 and sel 0x04; DELETE with hit=0 gives rsp NOTFOUND and no update.
REQ-025 CLEAR with ENTRIES_N=8: o_clr_vld for 8 consecutive cycles, idx 0..7, then rsp OK.
REQ-026 i_rsp_rdy held 0 for 5 cycles: o_rsp_vld and status held stable, o_cmd_rdy=0 throughout, and a new command is accepted only the cycle after rdy.
REQ-027 arst_n asserted during CLR at idx 3: outputs 0 immediately, IDLE with o_cmd_rdy=1 after release, and no response issued.

Source files
------------

// File: rtl/v_pipe_update_ctrl.sv
// Purpose: control FSM for a sorted/CAM-style table. It sequences key compare, one state update, a clear sweep and a response.
// Latency: INSERT/DELETE are accepted at T, compared at T+1, updated at T+2, and respond at T+3. NOP responds at T+1. CLEAR responds after ENTRIES_N clear cycles.
// Backpressure: one command in flight; o_cmd_rdy is high only when idle, and o_rsp_vld holds until i_rsp_rdy.
//
// Ports:
//   clk, arst_n                        clock, asynchronous active-low reset
//   i_cmd_vld/i_cmd_op/i_cmd_key       command ingress (op 0 NOP, 1 INSERT, 2 DELETE, 3 CLEAR)
//   o_cmd_rdy                          command accept
//   o_pipe_key_r                       registered key driven to the compare block
//   i_match_hit/full/sel, i_mask_cmp   compare results, used only in the compare cycle
//   o_upd_vld/op/sel/mask              table update strobe (op 1 INSERT-new, 2 DELETE, 3 MODIFY)
//   o_clr_vld/o_clr_idx                clear-sweep strobe and entry index
//   o_rsp_vld/o_rsp_status/i_rsp_rdy   response (status 0 OK, 1 FULL, 2 NOTFOUND)

package cfg_pkg;
  parameter int ENTRIES_N = 8;
endpackage

package v_pkg;
  parameter int KEY_W = 16;
  typedef logic [KEY_W-1:0] key_t;
endpackage

module v_pipe_update_ctrl #(
  parameter int CLR_IDX_W = $clog2(cfg_pkg::ENTRIES_N)
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          i_cmd_vld,
  input  logic [1:0]                    i_cmd_op,
  input  v_pkg::key_t                   i_cmd_key,
  output logic                          o_cmd_rdy,
  output v_pkg::key_t                   o_pipe_key_r,
  input  logic                          i_match_hit,
  input  logic                          i_match_full,
  input  logic [cfg_pkg::ENTRIES_N-1:0] i_match_sel,
  input  logic [cfg_pkg::ENTRIES_N-1:0] i_mask_cmp,
  output logic                          o_upd_vld,
  output logic [1:0]                    o_upd_op,
  output logic [cfg_pkg::ENTRIES_N-1:0] o_upd_sel,
  output logic [cfg_pkg::ENTRIES_N-1:0] o_upd_mask,
  output logic                          o_clr_vld,
  output logic [CLR_IDX_W-1:0]          o_clr_idx,
  output logic                          o_rsp_vld,
  output logic [1:0]                    o_rsp_status,
  input  logic                          i_rsp_rdy
);

  localparam int N = cfg_pkg::ENTRIES_N;

  localparam logic [1:0] CMD_NOP = 2'd0;
  localparam logic [1:0] CMD_INS = 2'd1;
  localparam logic [1:0] CMD_DEL = 2'd2;
  localparam logic [1:0] CMD_CLR = 2'd3;

  localparam logic [1:0] UPD_INS = 2'd1;
  localparam logic [1:0] UPD_DEL = 2'd2;
  localparam logic [1:0] UPD_MOD = 2'd3;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_FULL     = 2'd1;
  localparam logic [1:0] ST_NOTFOUND = 2'd2;

  localparam logic [CLR_IDX_W-1:0] CLR_LAST = CLR_IDX_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMP  = 3'd1,
    S_UPD  = 3'd2,
    S_CLR  = 3'd3,
    S_RSP  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  v_pkg::key_t     key_q, key_d;
  logic [1:0]      op_q, op_d;
  logic            hit_q, hit_d;
  logic            full_q, full_d;
  logic [N-1:0]    sel_q, sel_d;
  logic [N-1:0]    mask_q, mask_d;
  logic [1:0]      status_q, status_d;
  logic [CLR_IDX_W-1:0] clr_idx_q, clr_idx_d;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= S_IDLE;
      key_q     <= '0;
      op_q      <= '0;
      hit_q     <= 1'b0;
      full_q    <= 1'b0;
      sel_q     <= '0;
      mask_q    <= '0;
      status_q  <= ST_OK;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      op_q      <= op_d;
      hit_q     <= hit_d;
      full_q    <= full_d;
      sel_q     <= sel_d;
      mask_q    <= mask_d;
      status_q  <= status_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    op_d       = op_q;
    hit_d      = hit_q;
    full_d     = full_q;
    sel_d      = sel_q;
    mask_d     = mask_q;
    status_d   = status_q;
    clr_idx_d  = clr_idx_q;
    o_cmd_rdy  = 1'b0;
    o_upd_vld  = 1'b0;
    o_upd_op   = '0;
    o_upd_sel  = '0;
    o_upd_mask = '0;
    o_clr_vld  = 1'b0;
    o_rsp_vld  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        o_cmd_rdy = 1'b1;
        if (i_cmd_vld) begin
          unique case (i_cmd_op)
            CMD_NOP: begin
              status_d = ST_OK;
              state_d  = S_RSP;
            end
            CMD_INS, CMD_DEL: begin
              key_d   = i_cmd_key;
              op_d    = i_cmd_op;
              state_d = S_CMP;
            end
            CMD_CLR: begin
              clr_idx_d = '0;
              state_d   = S_CLR;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      // The compare block sees o_pipe_key_r this cycle. Its results are
      // captured only here, so match inputs in any other cycle are ignored.
      S_CMP: begin
        hit_d   = i_match_hit;
        full_d  = i_match_full;
        sel_d   = i_match_sel;
        mask_d  = i_mask_cmp;
        state_d = S_UPD;
      end

      S_UPD: begin
        state_d  = S_RSP;
        status_d = ST_OK;
        if (op_q == CMD_INS) begin
          if (hit_q) begin
            // The key already exists, so update it in place with no shift.
            o_upd_vld = 1'b1;
            o_upd_op  = UPD_MOD;
            o_upd_sel = sel_q;
          end else if (!full_q) begin
            o_upd_vld  = 1'b1;
            o_upd_op   = UPD_INS;
            o_upd_mask = mask_q;
          end else begin
            status_d = ST_FULL;
          end
        end else begin
          if (hit_q) begin
            o_upd_vld  = 1'b1;
            o_upd_op   = UPD_DEL;
            o_upd_sel  = sel_q;
            o_upd_mask = mask_q;
          end else begin
            status_d = ST_NOTFOUND;
          end
        end
      end

      // Stop at the last entry instead of wrapping, so exactly N strobes are issued.
      S_CLR: begin
        o_clr_vld = 1'b1;
        if (clr_idx_q == CLR_LAST) begin
          status_d = ST_OK;
          state_d  = S_RSP;
        end else begin
          clr_idx_d = clr_idx_q + CLR_IDX_W'(1);
        end
      end

      S_RSP: begin
        o_rsp_vld = 1'b1;
        if (i_rsp_rdy) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign o_pipe_key_r = key_q;
  assign o_clr_idx    = clr_idx_q;
  assign o_rsp_status = o_rsp_vld ? status_q : 2'd0;

endmodule

// File: tb/tb_v_pipe_update_ctrl.sv
module tb_v_pipe_update_ctrl;
  import v_pkg::key_t;

  localparam int N  = cfg_pkg::ENTRIES_N;
  localparam int IW = $clog2(N);

  typedef logic [N-1:0] vec_t;

  localparam logic [1:0] OP_NOP = 2'd0, OP_INS = 2'd1, OP_DEL = 2'd2, OP_CLR = 2'd3;

  // Every observable strobe-type output, collected into one value per cycle.
  typedef struct packed {
    logic       rdy;
    logic       upd_vld;
    logic [1:0] upd_op;
    vec_t       upd_sel;
    vec_t       upd_mask;
    logic       clr_vld;
    logic       rsp_vld;
    logic [1:0] rsp_status;
  } obs_t;

  logic clk = 1'b0;
  logic arst_n;
  logic i_cmd_vld;
  logic [1:0] i_cmd_op;
  key_t i_cmd_key;
  logic o_cmd_rdy;
  key_t o_pipe_key_r;
  logic i_match_hit, i_match_full;
  vec_t i_match_sel, i_mask_cmp;
  logic o_upd_vld;
  logic [1:0] o_upd_op;
  vec_t o_upd_sel, o_upd_mask;
  logic o_clr_vld;
  logic [IW-1:0] o_clr_idx;
  logic o_rsp_vld;
  logic [1:0] o_rsp_status;
  logic i_rsp_rdy;

  int n_checks = 0;
  int n_fail   = 0;
  key_t exp_key;

  always #5 clk = ~clk;

  v_pipe_update_ctrl dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .i_cmd_vld    (i_cmd_vld),
    .i_cmd_op     (i_cmd_op),
    .i_cmd_key    (i_cmd_key),
    .o_cmd_rdy    (o_cmd_rdy),
    .o_pipe_key_r (o_pipe_key_r),
    .i_match_hit  (i_match_hit),
    .i_match_full (i_match_full),
    .i_match_sel  (i_match_sel),
    .i_mask_cmp   (i_mask_cmp),
    .o_upd_vld    (o_upd_vld),
    .o_upd_op     (o_upd_op),
    .o_upd_sel    (o_upd_sel),
    .o_upd_mask   (o_upd_mask),
    .o_clr_vld    (o_clr_vld),
    .o_clr_idx    (o_clr_idx),
    .o_rsp_vld    (o_rsp_vld),
    .o_rsp_status (o_rsp_status),
    .i_rsp_rdy    (i_rsp_rdy)
  );

  function automatic obs_t observe();
    obs_t o;
    o.rdy        = o_cmd_rdy;
    o.upd_vld    = o_upd_vld;
    o.upd_op     = o_upd_op;
    o.upd_sel    = o_upd_sel;
    o.upd_mask   = o_upd_mask;
    o.clr_vld    = o_clr_vld;
    o.rsp_vld    = o_rsp_vld;
    o.rsp_status = o_rsp_status;
    return o;
  endfunction

  function automatic obs_t quiet(input logic rdy);
    obs_t o;
    o     = '0;
    o.rdy = rdy;
    return o;
  endfunction

  // Reference decision for the update cycle, written directly from the command rules.
  task automatic model_upd(input logic [1:0] op, input logic hit, input logic full,
                           input vec_t sel, input vec_t mask,
                           output obs_t e, output logic [1:0] st);
    e  = '0;
    st = 2'd0;
    if (op == OP_INS) begin
      if (hit) begin
        e.upd_vld = 1'b1; e.upd_op = 2'd3; e.upd_sel = sel;
      end else if (!full) begin
        e.upd_vld = 1'b1; e.upd_op = 2'd1; e.upd_mask = mask;
      end else begin
        st = 2'd1;
      end
    end else begin
      if (hit) begin
        e.upd_vld = 1'b1; e.upd_op = 2'd2; e.upd_sel = sel; e.upd_mask = mask;
      end else begin
        st = 2'd2;
      end
    end
  endtask

  task automatic scramble_cmp();
    i_match_hit  = 1'($urandom);
    i_match_full = 1'($urandom);
    i_match_sel  = vec_t'($urandom);
    i_mask_cmp   = vec_t'($urandom);
  endtask

  task automatic garbage_cmd();
    i_cmd_vld = 1'($urandom_range(0, 1));
    i_cmd_op  = 2'($urandom);
    i_cmd_key = key_t'($urandom);
  endtask

  // Issues one command at the next idle cycle and checks every cycle until the response is accepted.
  task automatic run_cmd(input logic [1:0] op, input key_t key, input logic hit, input logic full,
                         input vec_t sel, input vec_t mask, input int stall, input string tag);
    obs_t e;
    logic [1:0] st;
    @(negedge clk);
    n_checks++;
    if (observe() !== quiet(1'b1)) begin
      n_fail++; $display("FAIL %s idle: got %h want %h", tag, observe(), quiet(1'b1));
    end
    i_cmd_vld = 1'b1; i_cmd_op = op; i_cmd_key = key;
    i_rsp_rdy = 1'($urandom);
    scramble_cmp();
    st = 2'd0;
    if (op == OP_INS || op == OP_DEL) begin
      exp_key = key;
      @(negedge clk);
      n_checks++;
      if (observe() !== quiet(1'b0) || o_pipe_key_r !== exp_key) begin
        n_fail++; $display("FAIL %s cmp: got %h key %h want %h key %h", tag, observe(), o_pipe_key_r, quiet(1'b0), exp_key);
      end
      garbage_cmd();
      i_match_hit = hit; i_match_full = full; i_match_sel = sel; i_mask_cmp = mask;
      @(negedge clk);
      model_upd(op, hit, full, sel, mask, e, st);
      n_checks++;
      if (observe() !== e) begin
        n_fail++; $display("FAIL %s upd: got %h want %h", tag, observe(), e);
      end
      garbage_cmd();
      scramble_cmp();
    end else if (op == OP_CLR) begin
      for (int i = 0; i < N; i++) begin
        @(negedge clk);
        e = quiet(1'b0); e.clr_vld = 1'b1;
        n_checks++;
        if (observe() !== e || o_clr_idx !== IW'(i)) begin
          n_fail++; $display("FAIL %s clr%0d: got %h idx %0d want %h idx %0d", tag, i, observe(), o_clr_idx, e, i);
        end
        garbage_cmd();
        scramble_cmp();
      end
    end
    for (int c = 0; c <= stall; c++) begin
      @(negedge clk);
      e = quiet(1'b0); e.rsp_vld = 1'b1; e.rsp_status = st;
      n_checks++;
      if (observe() !== e || o_pipe_key_r !== exp_key) begin
        n_fail++; $display("FAIL %s rsp%0d: got %h key %h want %h key %h", tag, c, observe(), o_pipe_key_r, e, exp_key);
      end
      garbage_cmd();
      scramble_cmp();
      i_rsp_rdy = (c == stall);
    end
  endtask

  task automatic test_reset();
    obs_t o;
    #3;
    o = observe(); o.rdy = 1'b0;
    n_checks++;
    if (o !== '0 || o_pipe_key_r !== '0 || o_clr_idx !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h key %h idx %0d want 0", o, o_pipe_key_r, o_clr_idx);
    end
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (observe() !== quiet(1'b1)) begin
      n_fail++; $display("FAIL reset_release: got %h want %h", observe(), quiet(1'b1));
    end
  endtask

  task automatic test_insert();
    run_cmd(OP_INS, key_t'(16'h0010), 1'b0, 1'b0, vec_t'(8'h00), vec_t'(8'h03), 0, "ins_new");
    run_cmd(OP_INS, key_t'(16'h0022), 1'b1, 1'b0, vec_t'(8'h20), vec_t'(8'hF0), 0, "ins_hit");
    run_cmd(OP_INS, key_t'(16'h0033), 1'b0, 1'b1, vec_t'(8'h00), vec_t'(8'h7F), 0, "ins_full");
  endtask

  task automatic test_delete();
    run_cmd(OP_DEL, key_t'(16'h0010), 1'b1, 1'b0, vec_t'(8'h04), vec_t'(8'h0F), 0, "del_hit");
    run_cmd(OP_DEL, key_t'(16'h0044), 1'b0, 1'b1, vec_t'(8'h01), vec_t'(8'hFF), 0, "del_miss");
  endtask

  task automatic test_clear_nop();
    run_cmd(OP_CLR, key_t'(16'h0999), 1'b1, 1'b1, vec_t'(8'h01), vec_t'(8'hFF), 0, "clear");
    run_cmd(OP_NOP, key_t'(16'hABCD), 1'b1, 1'b0, vec_t'(8'h02), vec_t'(8'h0F), 0, "nop");
  endtask

  task automatic test_rsp_stall();
    run_cmd(OP_DEL, key_t'(16'h0055), 1'b0, 1'b0, vec_t'(8'h08), vec_t'(8'h3C), 5, "rsp_stall");
    run_cmd(OP_INS, key_t'(16'h0066), 1'b0, 1'b0, vec_t'(8'h00), vec_t'(8'h01), 0, "after_stall");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_cmd(OP_INS, key_t'(16'h0100 + i), 1'b0, 1'b0, vec_t'(8'h00), vec_t'(1 << i), 0, "b2b");
  endtask

  task automatic test_random();
    logic [1:0] op;
    int r;
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      op = (r == 0) ? OP_NOP : (r == 1) ? OP_CLR : (r < 6) ? OP_INS : OP_DEL;
      run_cmd(op, key_t'($urandom), 1'($urandom), 1'($urandom),
              vec_t'(1 << $urandom_range(0, N - 1)), vec_t'($urandom), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_reset_mid_clear();
    obs_t e;
    @(negedge clk);
    n_checks++;
    if (observe() !== quiet(1'b1)) begin
      n_fail++; $display("FAIL rst_clr idle: got %h want %h", observe(), quiet(1'b1));
    end
    i_cmd_vld = 1'b1; i_cmd_op = OP_CLR; i_cmd_key = key_t'($urandom);
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      e = quiet(1'b0); e.clr_vld = 1'b1;
      n_checks++;
      if (observe() !== e || o_clr_idx !== IW'(i)) begin
        n_fail++; $display("FAIL rst_clr clr%0d: got %h idx %0d want %h idx %0d", i, observe(), o_clr_idx, e, i);
      end
      garbage_cmd();
    end
    #1;
    arst_n = 1'b0;
    i_cmd_vld = 1'b0;
    #1;
    e = observe(); e.rdy = 1'b0;
    n_checks++;
    if (e !== '0 || o_clr_idx !== '0 || o_pipe_key_r !== '0) begin
      n_fail++; $display("FAIL rst_clr async: got %h idx %0d key %h want 0", e, o_clr_idx, o_pipe_key_r);
    end
    exp_key = '0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_checks++;
      if (observe() !== quiet(1'b1)) begin
        n_fail++; $display("FAIL rst_clr after%0d: got %h want %h", c, observe(), quiet(1'b1));
      end
      scramble_cmp();
      i_rsp_rdy = 1'($urandom);
    end
    run_cmd(OP_INS, key_t'(16'h0077), 1'b1, 1'b0, vec_t'(8'h80), vec_t'(8'h00), 0, "recover");
  endtask

  initial begin
    arst_n = 1'b0;
    i_cmd_vld = 1'b0; i_cmd_op = '0; i_cmd_key = '0;
    i_match_hit = 1'b0; i_match_full = 1'b0; i_match_sel = '0; i_mask_cmp = '0;
    i_rsp_rdy = 1'b0;
    exp_key = '0;
    test_reset();
    test_insert();
    test_delete();
    test_clear_nop();
    test_rsp_stall();
    test_back_to_back();
    test_random();
    test_reset_mid_clear();
    @(negedge clk);
    i_cmd_vld = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
